// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one data-memory port between the instruction-fetch
//             requester (IF) and the load/store unit (LSU). One transaction
//             is outstanding at a time, sequenced by an IDLE/REQ/WAIT/ERR
//             FSM. LSU has fixed priority, limited by a streak guard so a
//             waiting IF is not starved. LSU addresses are range/alignment
//             checked, and a stalled memory is aborted after a timeout.
//  Ports    :
//    clock, reset                 clock, synchronous active-high reset
//    if_req_i / if_addr_i         fetch request and byte address
//    if_gnt_o / if_rvalid_o       fetch accept pulse / response pulse
//    if_rdata_o / if_err_o        fetch read data / error flag
//    lsu_req_i / lsu_we_i         LSU request / store (1) or load (0)
//    lsu_addr_i / lsu_wdata_i     LSU byte address / store data
//    lsu_gnt_o / lsu_rvalid_o     LSU accept pulse / response pulse
//    lsu_rdata_o / lsu_err_o      LSU read data / error flag
//    mem_req_o / mem_we_o         memory request / write enable
//    mem_addr_o / mem_wdata_o     memory address / write data
//    mem_gnt_i / mem_rvalid_i     memory accept / response valid
//    mem_rdata_i                  memory read data
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int unsigned MAX_LSU_STREAK = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] DMEM_LO        = 32'd512,
  parameter logic [31:0] DMEM_HI        = 32'd8704
) (
  input  logic        clock,
  input  logic        reset,
  // instruction fetch
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  // load/store unit
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_gnt_o,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_err_o,
  // memory port
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  localparam int unsigned c_STREAK_W = $clog2(MAX_LSU_STREAK + 1);
  localparam int unsigned c_TMO_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_LSU_STREAK);
  localparam logic [c_TMO_W-1:0]    c_TMO_LAST   = c_TMO_W'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  owner_lsu_q, owner_lsu_d;
  logic [31:0]           addr_q, addr_d;
  logic                  we_q, we_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [c_STREAK_W-1:0] streak_q, streak_d;
  logic [c_TMO_W-1:0]    tmo_q, tmo_d;

  // Owner-independent response, routed to the owning requester below.
  logic        w_gnt;
  logic        w_rvalid;
  logic        w_err;
  logic [31:0] w_rdata;
  logic        w_mem_req;

  logic        w_lsu_wins;
  logic        w_lsu_legal;
  logic        w_if_legal;

  // LSU keeps priority until it has won MAX_LSU_STREAK times in a row
  // against a waiting IF.
  assign w_lsu_wins  = lsu_req_i && !(if_req_i && (streak_q == c_STREAK_MAX));
  assign w_lsu_legal = (lsu_addr_i[1:0] == 2'b00) &&
                       (lsu_addr_i >= DMEM_LO) && (lsu_addr_i <= DMEM_HI);
  assign w_if_legal  = (if_addr_i[1:0] == 2'b00);

  always_comb begin
    state_d     = state_q;
    owner_lsu_d = owner_lsu_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    streak_d    = streak_q;
    w_gnt       = 1'b0;
    w_rvalid    = 1'b0;
    w_err       = 1'b0;
    w_rdata     = 32'd0;
    w_mem_req   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (if_req_i || lsu_req_i) begin
          if (w_lsu_wins) begin
            owner_lsu_d = 1'b1;
            addr_d      = lsu_addr_i;
            we_d        = lsu_we_i;
            wdata_d     = lsu_wdata_i;
            if (!if_req_i) begin
              streak_d = '0;
            end else if (streak_q != c_STREAK_MAX) begin
              streak_d = streak_q + 1'b1;
            end
            state_d = w_lsu_legal ? S_REQ : S_ERR;
          end else begin
            owner_lsu_d = 1'b0;
            addr_d      = if_addr_i;
            we_d        = 1'b0;
            wdata_d     = 32'd0;
            streak_d    = '0;
            state_d     = w_if_legal ? S_REQ : S_ERR;
          end
        end
      end

      S_REQ: begin
        w_mem_req = 1'b1;
        // An accept on the last allowed cycle still wins over the timeout.
        if (mem_gnt_i) begin
          w_gnt   = 1'b1;
          state_d = S_WAIT;
        end else if (tmo_q == c_TMO_LAST) begin
          state_d = S_ERR;
        end
      end

      S_WAIT: begin
        if (mem_rvalid_i) begin
          w_rvalid = 1'b1;
          w_rdata  = mem_rdata_i;
          state_d  = S_IDLE;
        end else if (tmo_q == c_TMO_LAST) begin
          state_d = S_ERR;
        end
      end

      S_ERR: begin
        w_gnt    = 1'b1;
        w_rvalid = 1'b1;
        w_err    = 1'b1;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The counter restarts on every state entry, so each of REQ and WAIT
    // gets its own full budget.
    if (state_d != state_q) begin
      tmo_d = '0;
    end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
      tmo_d = tmo_q + 1'b1;
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_lsu_q <= 1'b0;
      addr_q      <= 32'd0;
      we_q        <= 1'b0;
      wdata_q     <= 32'd0;
      streak_q    <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_lsu_q <= owner_lsu_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
    end
  end

  // Outputs are forced low while reset is high so that a response arriving
  // in the reset cycle never reaches the requester.
  assign if_gnt_o     = !reset && !owner_lsu_q && w_gnt;
  assign if_rvalid_o  = !reset && !owner_lsu_q && w_rvalid;
  assign if_err_o     = !reset && !owner_lsu_q && w_err;
  assign if_rdata_o   = (!reset && !owner_lsu_q) ? w_rdata : 32'd0;

  assign lsu_gnt_o    = !reset && owner_lsu_q && w_gnt;
  assign lsu_rvalid_o = !reset && owner_lsu_q && w_rvalid;
  assign lsu_err_o    = !reset && owner_lsu_q && w_err;
  assign lsu_rdata_o  = (!reset && owner_lsu_q) ? w_rdata : 32'd0;

  assign mem_req_o    = !reset && w_mem_req;
  assign mem_we_o     = !reset && w_mem_req && we_q;
  assign mem_addr_o   = (!reset && w_mem_req) ? addr_q  : 32'd0;
  assign mem_wdata_o  = (!reset && w_mem_req) ? wdata_q : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter. Directed steps drive
//             the requesters; a small memory model answers the port. Expected
//             grants and responses are queued as stimulus is issued and are
//             consumed as the arbiter produces them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = 32'd0;
  logic        if_gnt_o, if_rvalid_o, if_err_o;
  logic [31:0] if_rdata_o;
  logic        lsu_req_i = 1'b0;
  logic        lsu_we_i = 1'b0;
  logic [31:0] lsu_addr_i = 32'd0;
  logic [31:0] lsu_wdata_i = 32'd0;
  logic        lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'd0;

  mem_port_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_gnt_o     (if_gnt_o),
    .if_rvalid_o  (if_rvalid_o),
    .if_rdata_o   (if_rdata_o),
    .if_err_o     (if_err_o),
    .lsu_req_i    (lsu_req_i),
    .lsu_we_i     (lsu_we_i),
    .lsu_addr_i   (lsu_addr_i),
    .lsu_wdata_i  (lsu_wdata_i),
    .lsu_gnt_o    (lsu_gnt_o),
    .lsu_rvalid_o (lsu_rvalid_o),
    .lsu_rdata_o  (lsu_rdata_o),
    .lsu_err_o    (lsu_err_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        is_lsu;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t rsp_q[$];
  logic gnt_q[$];   // 1 = LSU, 0 = IF

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // memory model controls/state
  logic mem_auto_gnt = 1'b0;
  int   rv_delay     = 0;
  logic force_rv     = 1'b0;
  logic mem_pend     = 1'b0;
  int   mem_dcnt     = 0;

  logic if_hold  = 1'b0;
  logic lsu_hold = 1'b0;

  // monitor records
  int          mem_req_cycles = 0;
  int          if_active_cycles = 0;
  int          last_if_gnt = -1, last_if_rv = -1;
  int          last_lsu_gnt = -1, last_lsu_rv = -1;
  logic        last_mem_we = 1'b0;
  logic [31:0] last_mem_addr = 32'd0, last_mem_wdata = 32'd0;
  logic        s_nonzero = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: memory model drives its inputs, outputs are sampled on
  // the falling edge and checked against the queues, requesters drop their
  // request after a grant unless held.
  task automatic step();
    logic drop_if, drop_lsu;
    logic g;
    rsp_t r;
    #1;
    mem_gnt_i    = mem_auto_gnt && mem_req_o;
    mem_rvalid_i = force_rv || (mem_pend && (mem_dcnt == 0));
    @(negedge clock);
    cyc++;
    s_nonzero = |{if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
                  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o,
                  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o};
    if (|{if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o}) if_active_cycles++;
    if (mem_req_o) begin
      mem_req_cycles++;
      last_mem_we    = mem_we_o;
      last_mem_addr  = mem_addr_o;
      last_mem_wdata = mem_wdata_o;
    end

    if (if_gnt_o) begin
      last_if_gnt = cyc;
      if (gnt_q.size() == 0) chk("unexpected_if_gnt", 32'(if_gnt_o), 32'd0);
      else begin g = gnt_q.pop_front(); chk("gnt_order_if", 32'(g), 32'd0); end
    end
    if (lsu_gnt_o) begin
      last_lsu_gnt = cyc;
      if (gnt_q.size() == 0) chk("unexpected_lsu_gnt", 32'(lsu_gnt_o), 32'd0);
      else begin g = gnt_q.pop_front(); chk("gnt_order_lsu", 32'(g), 32'd1); end
    end
    if (if_rvalid_o) begin
      last_if_rv = cyc;
      if (rsp_q.size() == 0) chk("unexpected_if_rvalid", 32'(if_rvalid_o), 32'd0);
      else begin
        r = rsp_q.pop_front();
        chk("rsp_owner_if", 32'(r.is_lsu), 32'd0);
        chk("if_rdata", if_rdata_o, r.rdata);
        chk("if_err", 32'(if_err_o), 32'(r.err));
      end
    end
    if (lsu_rvalid_o) begin
      last_lsu_rv = cyc;
      if (rsp_q.size() == 0) chk("unexpected_lsu_rvalid", 32'(lsu_rvalid_o), 32'd0);
      else begin
        r = rsp_q.pop_front();
        chk("rsp_owner_lsu", 32'(r.is_lsu), 32'd1);
        chk("lsu_rdata", lsu_rdata_o, r.rdata);
        chk("lsu_err", 32'(lsu_err_o), 32'(r.err));
      end
    end
    if (if_err_o && !if_rvalid_o) chk("if_err_without_rvalid", 32'(if_err_o), 32'd0);
    if (lsu_err_o && !lsu_rvalid_o) chk("lsu_err_without_rvalid", 32'(lsu_err_o), 32'd0);

    if (reset) begin
      mem_pend = 1'b0;
    end else begin
      if (mem_rvalid_i) mem_pend = 1'b0;
      else if (mem_pend) mem_dcnt--;
      if (mem_req_o && mem_gnt_i) begin
        mem_pend = 1'b1;
        mem_dcnt = rv_delay;
      end
    end
    drop_if  = if_gnt_o && !if_hold;
    drop_lsu = lsu_gnt_o && !lsu_hold;
    @(posedge clock);
    #1;
    if (drop_if)  if_req_i  = 1'b0;
    if (drop_lsu) lsu_req_i = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Single LSU transaction with an immediately answering memory.
  task automatic do_lsu(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input logic exp_err);
    int t0;
    mem_auto_gnt = 1'b1;
    rv_delay     = 0;
    mem_rdata_i  = rdata;
    lsu_we_i     = we;
    lsu_addr_i   = addr;
    lsu_wdata_i  = wdata;
    lsu_req_i    = 1'b1;
    gnt_q.push_back(1'b1);
    rsp_q.push_back('{is_lsu: 1'b1, rdata: (exp_err ? 32'd0 : rdata), err: exp_err});
    mem_req_cycles = 0;
    t0 = cyc + 1;
    steps(4);
    chk({tag, "_gnt_lat"}, 32'(last_lsu_gnt - t0), 32'd1);
    chk({tag, "_rv_lat"}, 32'(last_lsu_rv - t0), exp_err ? 32'd1 : 32'd2);
    chk({tag, "_mem_req_cycles"}, 32'(mem_req_cycles), exp_err ? 32'd0 : 32'd1);
    if (!exp_err) begin
      chk({tag, "_mem_addr"}, last_mem_addr, addr);
      chk({tag, "_mem_we"}, 32'(last_mem_we), 32'(we));
      chk({tag, "_mem_wdata"}, last_mem_wdata, wdata);
    end
  endtask

  task automatic do_if(input string tag, input logic [31:0] addr, input logic [31:0] rdata);
    int t0;
    mem_auto_gnt = 1'b1;
    rv_delay     = 0;
    mem_rdata_i  = rdata;
    if_addr_i    = addr;
    if_req_i     = 1'b1;
    gnt_q.push_back(1'b0);
    rsp_q.push_back('{is_lsu: 1'b0, rdata: rdata, err: 1'b0});
    mem_req_cycles = 0;
    t0 = cyc + 1;
    steps(4);
    chk({tag, "_gnt_lat"}, 32'(last_if_gnt - t0), 32'd1);
    chk({tag, "_rv_lat"}, 32'(last_if_rv - t0), 32'd2);
    chk({tag, "_mem_addr"}, last_mem_addr, addr);
    chk({tag, "_mem_we"}, 32'(last_mem_we), 32'd0);
  endtask

  initial begin
    int t0;
    int if_act0;

    // reset state
    reset = 1'b1;
    @(posedge clock);
    #1;
    step();
    chk("reset_outputs_zero", 32'(s_nonzero), 32'd0);
    reset = 1'b0;
    step();
    chk("idle_outputs_zero", 32'(s_nonzero), 32'd0);

    // LSU load, normal latency, IF side silent
    if_act0 = if_active_cycles;
    do_lsu("lsu_load", 1'b0, 32'h200, 32'd0, 32'hDEADBEEF, 1'b0);
    chk("lsu_load_if_quiet", 32'(if_active_cycles - if_act0), 32'd0);

    // illegal LSU accesses and range boundaries
    do_lsu("lsu_above_hi", 1'b1, 32'h2204, 32'h11111111, 32'h0, 1'b1);
    do_lsu("lsu_misaligned", 1'b1, 32'h202, 32'h22222222, 32'h0, 1'b1);
    do_lsu("lsu_below_lo", 1'b0, 32'h1FC, 32'h0, 32'h0, 1'b1);
    do_lsu("lsu_store_at_hi", 1'b1, 32'h2200, 32'hCAFEF00D, 32'h5A5A5A5A, 1'b0);
    do_lsu("lsu_load_at_lo", 1'b0, 32'h200, 32'h0, 32'h01020304, 1'b0);
    do_if("if_fetch", 32'h40, 32'h0BADC0DE);

    // both requesters held: LSU x4, IF, LSU x4, IF
    mem_auto_gnt = 1'b1;
    rv_delay     = 0;
    mem_rdata_i  = 32'h33334444;
    if_addr_i    = 32'h100;
    lsu_addr_i   = 32'h300;
    lsu_we_i     = 1'b0;
    if_hold      = 1'b1;
    lsu_hold     = 1'b1;
    if_req_i     = 1'b1;
    lsu_req_i    = 1'b1;
    for (int k = 0; k < 10; k++) begin
      gnt_q.push_back((k % 5) != 4);
      rsp_q.push_back('{is_lsu: ((k % 5) != 4), rdata: 32'h33334444, err: 1'b0});
    end
    steps(30);
    if_req_i  = 1'b0;
    lsu_req_i = 1'b0;
    if_hold   = 1'b0;
    lsu_hold  = 1'b0;
    steps(2);
    chk("streak_gnt_queue_drained", 32'(gnt_q.size()), 32'd0);
    chk("streak_rsp_queue_drained", 32'(rsp_q.size()), 32'd0);

    // LSU load with memory never accepting: timeout after 16 REQ cycles
    mem_auto_gnt = 1'b0;
    lsu_addr_i   = 32'h400;
    lsu_we_i     = 1'b0;
    lsu_req_i    = 1'b1;
    gnt_q.push_back(1'b1);
    rsp_q.push_back('{is_lsu: 1'b1, rdata: 32'd0, err: 1'b1});
    mem_req_cycles = 0;
    t0 = cyc + 1;
    steps(19);
    chk("tmo_mem_req_cycles", 32'(mem_req_cycles), 32'd16);
    chk("tmo_rv_lat", 32'(last_lsu_rv - t0), 32'd17);
    chk("tmo_gnt_lat", 32'(last_lsu_gnt - t0), 32'd17);
    do_if("if_after_tmo", 32'h0, 32'h76543210);

    // reset while waiting, with a response arriving in the reset cycle
    mem_auto_gnt = 1'b1;
    rv_delay     = 1000;
    lsu_addr_i   = 32'h200;
    lsu_we_i     = 1'b0;
    lsu_req_i    = 1'b1;
    gnt_q.push_back(1'b1);
    steps(2);
    reset       = 1'b1;
    force_rv    = 1'b1;
    mem_rdata_i = 32'hFFFF0000;
    step();
    chk("rst_in_wait_outputs_zero", 32'(s_nonzero), 32'd0);
    reset    = 1'b0;
    force_rv = 1'b0;
    step();
    chk("after_rst_outputs_zero", 32'(s_nonzero), 32'd0);
    do_lsu("lsu_after_rst", 1'b0, 32'h204, 32'd0, 32'h13572468, 1'b0);

    // response on the last timeout cycle wins over the timeout
    mem_auto_gnt = 1'b1;
    rv_delay     = 15;
    mem_rdata_i  = 32'hA5A5F00F;
    if_addr_i    = 32'h10;
    if_req_i     = 1'b1;
    gnt_q.push_back(1'b0);
    rsp_q.push_back('{is_lsu: 1'b0, rdata: 32'hA5A5F00F, err: 1'b0});
    t0 = cyc + 1;
    steps(20);
    chk("late_rv_lat", 32'(last_if_rv - t0), 32'd17);
    chk("late_gnt_lat", 32'(last_if_gnt - t0), 32'd1);

    chk("final_gnt_queue_empty", 32'(gnt_q.size()), 32'd0);
    chk("final_rsp_queue_empty", 32'(rsp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory port between the instruction-fetch requester (IF) and the load/store unit (LSU) using a req/gnt/rvalid handshake.
- Sits between the core (fetch stage and LSU) and the DRAM model.
- Sequences one outstanding transaction at a time through a 4-state FSM.
- Fixed LSU priority, with a starvation guard for IF, an LSU address-legality check, and a response timeout.

Parameters:
- MAX_LSU_STREAK, 4: consecutive LSU wins allowed while IF is waiting; the next arbitration then goes to IF.
- TIMEOUT_CYCLES, 16: cycles waited in REQ or WAIT before the transaction is aborted with an error.
- DMEM_LO, 512: lowest legal LSU byte address, inclusive.
- DMEM_HI, 8704: highest legal LSU byte address, inclusive.

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- if_req_i  in  1  fetch request; held until if_gnt_o
- if_addr_i  in  32  fetch byte address
- if_gnt_o  out  1  fetch request accepted (1-cycle pulse)
- if_rvalid_o  out  1  fetch response valid (1-cycle pulse)
- if_rdata_o  out  32  fetch read data
- if_err_o  out  1  fetch error, valid with if_rvalid_o
- lsu_req_i  in  1  LSU request; held until lsu_gnt_o
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_addr_i  in  32  LSU byte address
- lsu_wdata_i  in  32  store data
- lsu_gnt_o  out  1  LSU request accepted (pulse)
- lsu_rvalid_o  out  1  LSU response valid (pulse)
- lsu_rdata_o  out  32  load data
- lsu_err_o  out  1  LSU error, valid with lsu_rvalid_o
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data
- mem_gnt_i  in  1  memory accepted the request
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  32  memory read data

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE; streak and timeout counters clear.
  - Latched owner, address, we and wdata clear to 0.
  - All outputs are 0, including rdata buses; no output is ever high-Z.
  - Reset mid-transaction abandons it; no gnt or rvalid is issued for it.
- FSM states: IDLE, REQ, WAIT, ERR.
- IDLE, arbitration:
  - If only one requester is high, it wins.
  - If both are high, LSU wins unless streak == MAX_LSU_STREAK, in which case IF wins.
  - The winner's addr, we and wdata are latched as owner; IF always has we = 0.
- IDLE, legality check on the winner:
  - LSU is illegal if addr[1:0] != 0, addr < DMEM_LO, or addr > DMEM_HI.
  - IF is illegal if addr[1:0] != 0.
  - Illegal goes to ERR; legal goes to REQ.
- REQ:
  - mem_req_o = 1; mem_addr_o, mem_we_o and mem_wdata_o come from the latched registers.
  - On mem_gnt_i, the owner's gnt_o pulses in the same cycle (combinational) and the FSM goes to WAIT.
- WAIT:
  - mem_req_o = 0.
  - On mem_rvalid_i, the owner's rvalid_o pulses in the same cycle and its rdata_o = mem_rdata_i (stores return rdata, ignored by the LSU). err_o = 0. FSM goes to IDLE.
- ERR, one cycle:
  - The owner's gnt_o and rvalid_o pulse together, err_o = 1, rdata_o = 0. FSM goes to IDLE.
  - Memory is never requested.
- Timeout counter:
  - Clears on every state entry and increments each cycle spent in REQ or WAIT.
  - At count == TIMEOUT_CYCLES - 1 with no gnt or rvalid that cycle, the FSM goes to ERR; mem_req_o drops the next cycle.
  - A gnt or rvalid arriving on that same cycle takes precedence over the timeout.
  - In WAIT, stray mem_gnt_i is ignored. In IDLE/ERR, mem_rvalid_i is ignored.
- Streak counter:
  - Increments when LSU wins while if_req_i is high, saturating at MAX_LSU_STREAK.
  - Clears when IF wins, or when if_req_i is low at an arbitration.
- Non-owner outputs: all 0 at all times.
- Requester rule: drop req the cycle after gnt unless issuing a new request. A req held through to IDLE is treated as a new request.
- Minimum latency, legal request: req@t0 latched, mem_req_o@t1, gnt@t1 if mem_gnt_i, rvalid@t2 if mem_rvalid_i. Back-to-back throughput is one transaction per 3 cycles.
- Error latency: req@t0, gnt+rvalid+err@t1.

Test Plan:
- LSU load, addr 0x200, mem_gnt_i at t1, mem_rvalid_i with 0xDEADBEEF at t2 -> lsu_gnt_o@t1, lsu_rvalid_o@t2, lsu_rdata_o=0xDEADBEEF, lsu_err_o=0; IF outputs all 0.
- LSU store, addr 0x2204 (8708) -> ERR: lsu_gnt_o=lsu_rvalid_o=lsu_err_o=1@t1, mem_req_o never asserted. Repeat with addr 0x202 (misaligned) -> same response.
- if_req_i and lsu_req_i both held continuously, memory answers immediately -> grant order LSU ×4, then IF, then LSU ×4, then IF; streak clears after each IF grant.
- LSU load, addr 0x400, mem_gnt_i held low -> mem_req_o high for 16 cycles, then lsu_rvalid_o=lsu_err_o=1, then IDLE. Then an IF request at 0x0 completes normally.
- Reset asserted in WAIT with mem_rvalid_i arriving the same cycle -> no rvalid pulse; all outputs 0 next cycle; the next request is served normally.
- IF fetch at 0x10 with mem_rvalid_i arriving exactly at timeout count 15 -> normal response with if_err_o=0 (response beats timeout).
